// File: rtl/sun2_timer_ctl.sv
// -----------------------------------------------------------------------------
// sun2_timer_ctl
//
// Timer controller for the CPU board. It has three functions:
//   * Refresh: divides the `ce` timebase by REFRESH_DIV and queues refresh
//     requests in a saturating pending counter (0..PEND_MAX). A request that
//     arrives while the queue is full sets a sticky overflow flag.
//   * Bus timeout: flags a bus error when an address strobe stays active for
//     TIMEOUT_CYC `ce` ticks, or when an external timeout arrives during it.
//   * Watchdog (optional): asserts `init` for INIT_LEN clocks after the CPU
//     has been halted for WDOG_CYC `ce` ticks without another bus master.
//
// Build option:
//   SUN2_TIMER_WDOG_EN - define to build the watchdog. When undefined, `init`
//                        simply follows `reset` one edge late, and `halt` and
//                        `sysb` are ignored.
//
// Ports:
//   CLK    in   system clock, all logic on the rising edge
//   reset  in   synchronous active-high reset
//   ce     in   timebase enable; counters advance only when high
//   ren    in   refresh grant, one pulse consumes one pending request
//   as     in   address strobe active (active-high)
//   tin    in   external timeout, qualified by `as`
//   halt   in   CPU halted
//   sysb   in   bus owned by another master, suppresses the watchdog
//   rreq   out  refresh request, high while `pend` is non-zero
//   pend   out  pending refresh count, 0..PEND_MAX
//   rovf   out  sticky refresh overflow
//   berr   out  bus timeout / bus error
//   init   out  board init / reset-out
// -----------------------------------------------------------------------------
module sun2_timer_ctl #(
  parameter int REFRESH_DIV = 64,
  parameter int PEND_MAX    = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int WDOG_CYC    = 128,
  parameter int INIT_LEN    = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ce,
  input  logic       ren,
  input  logic       as,
  input  logic       tin,
  input  logic       halt,
  input  logic       sysb,
  output logic       rreq,
  output logic [3:0] pend,
  output logic       rovf,
  output logic       berr,
  output logic       init
);

  localparam int RCNT_W = $clog2(REFRESH_DIV);
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]        PEND_TOP  = 4'(PEND_MAX);
  localparam logic [TCNT_W-1:0] TCNT_LIM  = TCNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } t_bus_st;

  // Refresh path
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic [3:0]        r_pend;
  logic [3:0]        w_pend_nxt;
  logic              r_rreq;
  logic              r_rovf;
  logic              w_rovf_nxt;
  logic              w_tick;

  // Bus timeout path
  t_bus_st           r_st;
  t_bus_st           w_st_nxt;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic              w_tmo;
  logic              r_berr;

  // Watchdog fire strobe; tied low when the watchdog is not built
  logic              w_fire;
  logic              r_init;

  // ---------------------------------------------------------------------------
  // Refresh divider and pending-request queue
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tick     = ce && (r_rcnt == RCNT_LAST);
    w_rcnt_nxt = r_rcnt;
    w_pend_nxt = r_pend;
    w_rovf_nxt = r_rovf;

    if (ce) begin
      w_rcnt_nxt = w_tick ? '0 : r_rcnt + 1'b1;
    end

    // A tick and a grant in the same cycle cancel each other out.
    if (w_tick && !ren) begin
      if (r_pend == PEND_TOP) begin
        w_rovf_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_pend + 4'd1;
      end
    end else if (ren && !w_tick && (r_pend != 4'd0)) begin
      w_pend_nxt = r_pend - 4'd1;
    end

    // A watchdog fire restarts the refresh timebase and drops the queue;
    // the overflow flag is left alone, only reset clears it.
    if (w_fire) begin
      w_rcnt_nxt = '0;
      w_pend_nxt = 4'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_rcnt <= '0;
      r_pend <= 4'd0;
      r_rreq <= 1'b0;
      r_rovf <= 1'b0;
    end else begin
      r_rcnt <= w_rcnt_nxt;
      r_pend <= w_pend_nxt;
      r_rreq <= (w_pend_nxt != 4'd0);
      r_rovf <= w_rovf_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus timeout FSM
  // ---------------------------------------------------------------------------
  // The tick counter runs on every cycle the strobe is active, including the
  // cycle it first appears, so the error lands on the edge of the
  // TIMEOUT_CYC-th tick. The counter saturates so ERR can hold indefinitely.
  always_comb begin
    w_tcnt_nxt = '0;
    if (as) begin
      w_tcnt_nxt = r_tcnt;
      if (ce && (r_tcnt != TCNT_LIM)) begin
        w_tcnt_nxt = r_tcnt + 1'b1;
      end
    end
    w_tmo = tin || (w_tcnt_nxt == TCNT_LIM);

    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE, ST_RUN: begin
        if (!as) begin
          w_st_nxt = ST_IDLE;
        end else if (w_tmo) begin
          w_st_nxt = ST_ERR;
        end else begin
          w_st_nxt = ST_RUN;
        end
      end
      ST_ERR: begin
        w_st_nxt = as ? ST_ERR : ST_IDLE;
      end
      default: begin
        w_st_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_st   <= ST_IDLE;
      r_tcnt <= '0;
      r_berr <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_berr <= (w_st_nxt == ST_ERR);
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog and init stretch
  // ---------------------------------------------------------------------------
`ifdef SUN2_TIMER_WDOG_EN
  localparam int WCNT_W = $clog2(WDOG_CYC + 1);
  localparam int SCNT_W = $clog2(INIT_LEN + 1);

  localparam logic [WCNT_W-1:0] WCNT_LIM  = WCNT_W'(WDOG_CYC);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(INIT_LEN - 1);

  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [SCNT_W-1:0] r_scnt;

  // The halt counter restarts from zero on the fire edge, so a CPU that
  // stays halted fires again WDOG_CYC ticks later and reloads the stretch.
  always_comb begin
    w_fire     = 1'b0;
    w_wcnt_nxt = '0;
    if (halt && !sysb) begin
      w_wcnt_nxt = ce ? r_wcnt + 1'b1 : r_wcnt;
      if (w_wcnt_nxt == WCNT_LIM) begin
        w_fire     = 1'b1;
        w_wcnt_nxt = '0;
      end
    end
  end

  // r_scnt holds the number of init cycles still owed after the current one.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wcnt <= '0;
      r_scnt <= '0;
      r_init <= 1'b1;
    end else begin
      r_wcnt <= w_wcnt_nxt;
      if (w_fire) begin
        r_scnt <= SCNT_LOAD;
        r_init <= 1'b1;
      end else begin
        r_init <= (r_scnt != '0);
        if (r_scnt != '0) begin
          r_scnt <= r_scnt - 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_wdog;

  assign w_fire        = 1'b0;
  assign w_unused_wdog = &{1'b0, halt, sysb};

  // Without the watchdog, init is just reset delayed by one edge.
  always_ff @(posedge CLK) begin
    r_init <= reset;
  end
`endif

  assign rreq = r_rreq;
  assign pend = r_pend;
  assign rovf = r_rovf;
  assign berr = r_berr;
  assign init = r_init;

endmodule
